hamming_decoder: RTL and testbench

HAMMING_DECODER -- requirements
Module: hamming_decoder

---
 rtl/hamming_decoder.sv | 106 ++++++++++
 tb/tb_hamming_decoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder.sv
// Hamming(7,4) single-error-correcting decoder: a 3-step pipeline-less FSM
// (capture word, compute syndrome, correct and publish) with a held result.
module hamming_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [6:0] codeword,
  output logic       ready,
  output logic [3:0] message
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYND = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       load_word;
  logic       load_synd;
  logic       load_msg;

  logic [6:0] word_q;
  logic [2:0] synd_q;
  logic [2:0] synd_c;
  logic [6:0] fix_mask;
  logic [6:0] corrected;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load_word  = 1'b0;
    load_synd  = 1'b0;
    load_msg   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (valid) begin
          load_word  = 1'b1;
          state_next = SYND;
        end
      end
      SYND: begin
        load_synd  = 1'b1;
        state_next = CORR;
      end
      CORR: begin
        load_msg   = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Syndrome bit k is the parity over positions whose index has bit k set.
  always_comb begin
    synd_c[0] = word_q[0] ^ word_q[2] ^ word_q[4] ^ word_q[6];
    synd_c[1] = word_q[1] ^ word_q[2] ^ word_q[5] ^ word_q[6];
    synd_c[2] = word_q[3] ^ word_q[4] ^ word_q[5] ^ word_q[6];
  end

  // The syndrome names the 1-based position of the flipped bit; zero means clean.
  always_comb begin
    fix_mask = 7'b0000000;
    case (synd_q)
      3'd1:    fix_mask = 7'b0000001;
      3'd2:    fix_mask = 7'b0000010;
      3'd3:    fix_mask = 7'b0000100;
      3'd4:    fix_mask = 7'b0001000;
      3'd5:    fix_mask = 7'b0010000;
      3'd6:    fix_mask = 7'b0100000;
      3'd7:    fix_mask = 7'b1000000;
      default: fix_mask = 7'b0000000;
    endcase
    corrected = word_q ^ fix_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q  <= '0;
      synd_q  <= '0;
      ready   <= 1'b0;
      message <= '0;
    end else begin
      if (load_word) begin
        word_q <= codeword;
        ready  <= 1'b0;
      end
      if (load_synd) synd_q <= synd_c;
      if (load_msg) begin
        message <= {corrected[6], corrected[5], corrected[4], corrected[2]};
        ready   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed and randomised single-error checks for hamming_decoder; expected
// messages come from hand-worked vectors and an independent encoder.
module tb_hamming_decoder;

  logic       clk;
  logic       reset;
  logic       valid;
  logic [6:0] codeword;
  logic       ready;
  logic [3:0] message;

  int checks = 0;
  int errors = 0;

  hamming_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .codeword (codeword),
    .ready    (ready),
    .message  (message)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns so outputs are sampled off-edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle valid pulse; the codeword is then scrambled to prove it is
  // only sampled at the accepting edge.
  task automatic pulse(input logic [6:0] cw);
    valid    = 1'b1;
    codeword = cw;
    step();
    valid    = 1'b0;
    codeword = ~cw;
  endtask

  // Independent systematic encoder: data d -> positions 3,5,6,7 with even parity.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    valid    = 1'b0;
    codeword = 7'b0000000;
    step();
    step();
    checks++;
    if (ready !== 1'b0 || message !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state ready=%b message=%b expected ready=0 message=0000", ready, message);
    end
    // Reset wins over a simultaneous valid: nothing may start.
    valid    = 1'b1;
    codeword = 7'b1111111;
    step();
    reset = 1'b0;
    valid = 1'b0;
    step();
    step();
    step();
    checks++;
    if (ready !== 1'b0 || message !== 4'b0000) begin
      errors++;
      $display("FAIL reset_priority ready=%b message=%b expected ready=0 message=0000", ready, message);
    end
  endtask

  task automatic test_clean();
    pulse(7'b1010101);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL clean_e0 ready=%b expected 0", ready);
    end
    step();
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL clean_e1 ready=%b expected 0", ready);
    end
    step();
    checks++;
    if (ready !== 1'b1 || message !== 4'b1011) begin
      errors++;
      $display("FAIL clean_e2 ready=%b message=%b expected ready=1 message=1011", ready, message);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ready !== 1'b1 || message !== 4'b1011) begin
        errors++;
        $display("FAIL clean_hold[%0d] ready=%b message=%b expected ready=1 message=1011", i, ready, message);
      end
    end
  endtask

  task automatic test_data_error();
    pulse(7'b1000101);
    step();
    step();
    checks++;
    if (ready !== 1'b1 || message !== 4'b1011) begin
      errors++;
      $display("FAIL data_error ready=%b message=%b expected ready=1 message=1011", ready, message);
    end
  endtask

  task automatic test_parity_error();
    pulse(7'b1111110);
    step();
    step();
    checks++;
    if (ready !== 1'b1 || message !== 4'b1111) begin
      errors++;
      $display("FAIL parity_error ready=%b message=%b expected ready=1 message=1111", ready, message);
    end
    pulse(7'b0000000);
    step();
    step();
    checks++;
    if (ready !== 1'b1 || message !== 4'b0000) begin
      errors++;
      $display("FAIL clean_zero ready=%b message=%b expected ready=1 message=0000", ready, message);
    end
  endtask

  task automatic test_back_to_back();
    // Sits in DONE with message 0000; a new valid must restart immediately.
    pulse(7'b1111111);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drop ready=%b expected 0", ready);
    end
    step();
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_e1 ready=%b expected 0", ready);
    end
    step();
    checks++;
    if (ready !== 1'b1 || message !== 4'b1111) begin
      errors++;
      $display("FAIL b2b_e2 ready=%b message=%b expected ready=1 message=1111", ready, message);
    end
  endtask

  task automatic test_busy_ignore();
    pulse(7'b1010101);
    valid    = 1'b1;
    codeword = 7'b0000000;
    step();
    valid = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_e1 ready=%b expected 0", ready);
    end
    step();
    checks++;
    if (ready !== 1'b1 || message !== 4'b1011) begin
      errors++;
      $display("FAIL busy_e2 ready=%b message=%b expected ready=1 message=1011", ready, message);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ready !== 1'b1 || message !== 4'b1011) begin
        errors++;
        $display("FAIL busy_hold[%0d] ready=%b message=%b expected ready=1 message=1011", i, ready, message);
      end
    end
  endtask

  task automatic test_reset_mid();
    pulse(7'b1111111);
    step();
    reset = 1'b1;
    step();
    checks++;
    if (ready !== 1'b0 || message !== 4'b0000) begin
      errors++;
      $display("FAIL reset_corr ready=%b message=%b expected ready=0 message=0000", ready, message);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ready !== 1'b0 || message !== 4'b0000) begin
        errors++;
        $display("FAIL reset_abort[%0d] ready=%b message=%b expected ready=0 message=0000", i, ready, message);
      end
    end
    pulse(7'b1010101);
    step();
    step();
    checks++;
    if (ready !== 1'b1 || message !== 4'b1011) begin
      errors++;
      $display("FAIL reset_fresh ready=%b message=%b expected ready=1 message=1011", ready, message);
    end
  endtask

  task automatic test_random();
    logic [3:0] data;
    logic [6:0] cw;
    int         pos;
    for (int i = 0; i < 100; i++) begin
      data = 4'($urandom_range(0, 15));
      pos  = int'($urandom_range(0, 6));
      cw   = encode(data);
      cw[pos] = ~cw[pos];
      pulse(cw);
      step();
      step();
      checks++;
      if (ready !== 1'b1 || message !== data) begin
        errors++;
        $display("FAIL random[%0d] cw=%b ready=%b message=%b expected ready=1 message=%b",
                 i, cw, ready, message, data);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    valid    = 1'b0;
    codeword = 7'b0000000;
    test_reset();
    test_clean();
    test_data_error();
    test_parity_error();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
